regfile_ctrl: RTL and testbench



---
 rtl/regfile_ctrl_pkg.sv | 35 +++
 rtl/regfile_ctrl_if.sv | 27 ++
 rtl/regfile_ctrl_alu.sv | 35 +++
 rtl/regfile_ctrl.sv | 155 +++++++++++++++
 tb/tb_regfile_ctrl.sv | 232 +++++++++++++++++++++++
 5 files changed

// File: rtl/regfile_ctrl_pkg.sv
// Shared types and width constants for the regfile sequencing controller.
//   RC_W      data width of the 8-entry regfile
//   RC_RW     register index width
//   RC_IMM_W  MOVI immediate width
package regfile_ctrl_pkg;

   localparam int unsigned RC_W     = 16;
   localparam int unsigned RC_RW    = 3;
   localparam int unsigned RC_IMM_W = 8;

   typedef enum logic [2:0] {
      ST_IDLE  = 3'd0,
      ST_LOADA = 3'd1,
      ST_LOADB = 3'd2,
      ST_WRITE = 3'd3,
      ST_DONE  = 3'd4
   } rc_state_t;

   typedef enum logic [1:0] {
      OP_MOVI = 2'b00,
      OP_MOV  = 2'b01,
      OP_ADD  = 2'b10,
      OP_AND  = 2'b11
   } rc_op_t;

   // Micro-op captured at acceptance.
   typedef struct packed {
      rc_op_t                op;
      logic [RC_RW-1:0]      rd;
      logic [RC_RW-1:0]      rn;
      logic [RC_RW-1:0]      rm;
      logic [RC_IMM_W-1:0]   imm8;
   } rc_req_t;

endpackage

// File: rtl/regfile_ctrl_if.sv
// Regfile port bundle: one combinational read port, one clocked write port.
//   readnum     read index           (controller -> regfile)
//   writenum    write index          (controller -> regfile)
//   write       write enable         (controller -> regfile)
//   data_in     write data           (controller -> regfile)
//   rf_data_out read data            (regfile -> controller)
interface regfile_ctrl_if
   import regfile_ctrl_pkg::*;
#(
   parameter int unsigned W = RC_W
);
   logic [RC_RW-1:0] readnum;
   logic [RC_RW-1:0] writenum;
   logic             write;
   logic [W-1:0]     data_in;
   logic [W-1:0]     rf_data_out;

   modport master (
      output readnum, writenum, write, data_in,
      input  rf_data_out
   );

   modport slave (
      input  readnum, writenum, write, data_in,
      output rf_data_out
   );
endinterface

// File: rtl/regfile_ctrl_alu.sv
// rc_alu: combinational result and flags for one register-transfer micro-op.
//   op      micro-op encoding
//   a, b    latched operands
//   imm8    MOVI immediate (sign-extended to W)
//   result  value to write back
//   z, n    zero / negative flags of result
module rc_alu
   import regfile_ctrl_pkg::*;
#(
   parameter int unsigned W = RC_W
) (
   input  rc_op_t              op,
   input  logic [W-1:0]        a,
   input  logic [W-1:0]        b,
   input  logic [RC_IMM_W-1:0] imm8,
   output logic [W-1:0]        result,
   output logic                z,
   output logic                n
);

   always_comb begin
      result = '0;
      case (op)
         OP_MOVI: result = {{(W-RC_IMM_W){imm8[RC_IMM_W-1]}}, imm8};
         OP_MOV:  result = b;
         OP_ADD:  result = a + b;   // carry out intentionally dropped
         OP_AND:  result = a & b;
         default: result = '0;
      endcase
   end

   assign z = (result == '0);
   assign n = result[W-1];

endmodule

// File: rtl/regfile_ctrl.sv
// regfile_ctrl: executes one MOVI/MOV/ADD/AND micro-op per accepted start by
// reading operands through the single regfile read port, then writing back.
//   clk, reset        clock, synchronous active-high reset
//   start             request, sampled only in IDLE
//   op, rd, rn, rm    micro-op and register indices
//   imm8              MOVI immediate
//   rf                regfile bus (master side)
//   busy              high in every state but IDLE
//   done              one-cycle completion pulse
//   Z, N              flags of the last written result
module regfile_ctrl
   import regfile_ctrl_pkg::*;
#(
   parameter int unsigned W = RC_W
) (
   input  logic                clk,
   input  logic                reset,
   input  logic                start,
   input  logic [1:0]          op,
   input  logic [RC_RW-1:0]    rd,
   input  logic [RC_RW-1:0]    rn,
   input  logic [RC_RW-1:0]    rm,
   input  logic [RC_IMM_W-1:0] imm8,
   regfile_ctrl_if.master      rf,
   output logic                busy,
   output logic                done,
   output logic                Z,
   output logic                N
);

   rc_state_t        state;
   rc_req_t          req_q;
   rc_req_t          req_in;
   logic [W-1:0]     a_q;
   logic [W-1:0]     b_q;
   logic [RC_RW-1:0] readnum_q;
   logic [RC_RW-1:0] writenum_q;
   logic             write_q;
   logic [W-1:0]     data_in_q;
   logic             z_pend;
   logic             n_pend;

   rc_op_t           alu_op;
   logic [RC_IMM_W-1:0] alu_imm;
   logic [W-1:0]     alu_b;
   logic [W-1:0]     alu_res;
   logic             alu_z;
   logic             alu_n;

   assign req_in = '{op: rc_op_t'(op), rd: rd, rn: rn, rm: rm, imm8: imm8};

   // ALU evaluates the value that WRITE will present, one cycle early, so
   // data_in can be a register: from the live request for MOVI out of IDLE,
   // and from the read port for the operand being loaded in LOADB.
   assign alu_op  = (state == ST_IDLE) ? req_in.op   : req_q.op;
   assign alu_imm = (state == ST_IDLE) ? req_in.imm8 : req_q.imm8;
   assign alu_b   = (state == ST_LOADB) ? rf.rf_data_out : b_q;

   rc_alu #(.W(W)) u_alu (
      .op     (alu_op),
      .a      (a_q),
      .b      (alu_b),
      .imm8   (alu_imm),
      .result (alu_res),
      .z      (alu_z),
      .n      (alu_n)
   );

   // Sequencer with registered outputs decoded for the state being entered.
   always_ff @(posedge clk) begin
      if (reset) begin
         state      <= ST_IDLE;
         req_q      <= '0;
         a_q        <= '0;
         b_q        <= '0;
         readnum_q  <= '0;
         writenum_q <= '0;
         write_q    <= 1'b0;
         data_in_q  <= '0;
         z_pend     <= 1'b0;
         n_pend     <= 1'b0;
         busy       <= 1'b0;
         done       <= 1'b0;
         Z          <= 1'b0;
         N          <= 1'b0;
      end else begin
         readnum_q  <= '0;
         writenum_q <= '0;
         write_q    <= 1'b0;
         data_in_q  <= '0;
         done       <= 1'b0;
         case (state)
            ST_IDLE: begin
               if (start) begin
                  req_q <= req_in;
                  busy  <= 1'b1;
                  case (req_in.op)
                     OP_MOVI: begin
                        state      <= ST_WRITE;
                        write_q    <= 1'b1;
                        writenum_q <= req_in.rd;
                        data_in_q  <= alu_res;
                        z_pend     <= alu_z;
                        n_pend     <= alu_n;
                     end
                     OP_MOV: begin
                        state     <= ST_LOADB;
                        readnum_q <= req_in.rm;
                     end
                     default: begin
                        state     <= ST_LOADA;
                        readnum_q <= req_in.rn;
                     end
                  endcase
               end
            end
            ST_LOADA: begin
               a_q       <= rf.rf_data_out;
               state     <= ST_LOADB;
               readnum_q <= req_q.rm;
            end
            ST_LOADB: begin
               b_q        <= rf.rf_data_out;
               state      <= ST_WRITE;
               write_q    <= 1'b1;
               writenum_q <= req_q.rd;
               data_in_q  <= alu_res;
               z_pend     <= alu_z;
               n_pend     <= alu_n;
            end
            ST_WRITE: begin
               Z     <= z_pend;
               N     <= n_pend;
               state <= ST_DONE;
               done  <= 1'b1;
            end
            ST_DONE: begin
               state <= ST_IDLE;
               busy  <= 1'b0;
            end
            default: begin
               state <= ST_IDLE;
               busy  <= 1'b0;
            end
         endcase
      end
   end

   assign rf.readnum  = readnum_q;
   assign rf.writenum = writenum_q;
   assign rf.data_in  = data_in_q;
   // Reset in the WRITE cycle must block the regfile update at that same edge.
   assign rf.write    = write_q & ~reset;

endmodule

// File: tb/tb_regfile_ctrl.sv
// Self-checking bench for regfile_ctrl with a behavioural 8x16 regfile.
module tb_regfile_ctrl;
   import regfile_ctrl_pkg::*;

   typedef struct {
      logic        pre_en;
      logic [2:0]  pre_idx;
      logic [15:0] pre_val;
      logic [1:0]  op;
      logic [2:0]  rd;
      logic [2:0]  rn;
      logic [2:0]  rm;
      logic [7:0]  imm;
      logic [15:0] exp_val;
      int          exp_lat;
      logic        exp_z;
      logic        exp_n;
   } vec_t;

   typedef struct {
      logic [2:0]  rd;
      logic [15:0] val;
      int          lat;
      logic        z;
      logic        n;
   } exp_t;

   logic        clk = 1'b0;
   logic        reset;
   logic        start;
   logic [1:0]  op;
   logic [2:0]  rd, rn, rm;
   logic [7:0]  imm8;
   logic        busy, done, Z, N;

   logic        tb_we;
   logic [2:0]  tb_wn;
   logic [15:0] tb_wd;
   logic [15:0] regs [8];
   logic [15:0] mdl  [8];

   int checks = 0;
   int errors = 0;
   exp_t sb[$];
   vec_t vecs[11];

   regfile_ctrl_if #(.W(16)) rf ();

   regfile_ctrl #(.W(16)) dut (
      .clk   (clk),
      .reset (reset),
      .start (start),
      .op    (op),
      .rd    (rd),
      .rn    (rn),
      .rm    (rm),
      .imm8  (imm8),
      .rf    (rf),
      .busy  (busy),
      .done  (done),
      .Z     (Z),
      .N     (N)
   );

   always #5 clk = ~clk;

   // Behavioural regfile; the bench-side write port is used only for preloads.
   always @(posedge clk) begin
      if (tb_we) regs[tb_wn] <= tb_wd;
      else if (rf.write) regs[rf.writenum] <= rf.data_in;
   end
   assign rf.rf_data_out = regs[rf.readnum];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic chk_all();
      for (int i = 0; i < 8; i++)
         chk($sformatf("R%0d", i), 32'(regs[i]), 32'(mdl[i]));
   endtask

   task automatic chk_reset_outs(input string tag);
      chk({tag, "_busy"},     32'(busy),        32'd0);
      chk({tag, "_done"},     32'(done),        32'd0);
      chk({tag, "_write"},    32'(rf.write),    32'd0);
      chk({tag, "_readnum"},  32'(rf.readnum),  32'd0);
      chk({tag, "_writenum"}, 32'(rf.writenum), 32'd0);
      chk({tag, "_data_in"},  32'(rf.data_in),  32'd0);
      chk({tag, "_Z"},        32'(Z),           32'd0);
      chk({tag, "_N"},        32'(N),           32'd0);
   endtask

   task automatic preload(input logic [2:0] idx, input logic [15:0] val);
      @(negedge clk);
      tb_we = 1'b1; tb_wn = idx; tb_wd = val;
      mdl[idx] = val;
      @(negedge clk);
      tb_we = 1'b0;
   endtask

   task automatic drive(input logic [1:0] o, input logic [2:0] d, input logic [2:0] n,
                        input logic [2:0] m, input logic [7:0] i);
      op = o; rd = d; rn = n; rm = m; imm8 = i; start = 1'b1;
   endtask

   // One op: push expectation at drive, pop and compare when done appears.
   task automatic run_op(input vec_t v);
      exp_t e;
      int   lat;
      if (v.pre_en) preload(v.pre_idx, v.pre_val);
      @(negedge clk);
      drive(v.op, v.rd, v.rn, v.rm, v.imm);
      sb.push_back('{v.rd, v.exp_val, v.exp_lat, v.exp_z, v.exp_n});
      mdl[v.rd] = v.exp_val;
      @(negedge clk);
      start = 1'b0;
      lat = 1;
      chk("busy_cycle1", 32'(busy), 32'd1);
      while (!done && lat < 20) begin
         @(negedge clk);
         lat++;
      end
      e = sb.pop_front();
      chk("done_cycle", 32'(lat), 32'(e.lat));
      chk("dest_value", 32'(regs[e.rd]), 32'(e.val));
      chk("flag_Z", 32'(Z), 32'(e.z));
      chk("flag_N", 32'(N), 32'(e.n));
      chk_all();
      @(negedge clk);
      chk("busy_idle", 32'(busy), 32'd0);
   endtask

   initial begin
      int dn, dncyc, wr;
      vec_t v;
      reset = 1'b1; start = 1'b0; op = '0; rd = '0; rn = '0; rm = '0; imm8 = '0;
      tb_we = 1'b0; tb_wn = '0; tb_wd = '0;
      for (int i = 0; i < 8; i++) preload(3'(i), 16'h0000);
      preload(3'd2, 16'h0F0F);
      @(negedge clk);
      chk_reset_outs("reset");
      reset = 1'b0;

      //         pre  idx   val       op     rd    rn    rm    imm     exp       lat z     n
      vecs[0]  = '{1'b0, 3'd0, 16'h0000, 2'b00, 3'd3, 3'd0, 3'd0, 8'd42,  16'h002A, 2, 1'b0, 1'b0};
      vecs[1]  = '{1'b0, 3'd0, 16'h0000, 2'b00, 3'd1, 3'd0, 3'd0, 8'hF6,  16'hFFF6, 2, 1'b0, 1'b1};
      vecs[2]  = '{1'b0, 3'd0, 16'h0000, 2'b01, 3'd6, 3'd0, 3'd1, 8'h00,  16'hFFF6, 3, 1'b0, 1'b1};
      vecs[3]  = '{1'b0, 3'd0, 16'h0000, 2'b10, 3'd5, 3'd3, 3'd3, 8'h00,  16'h0054, 4, 1'b0, 1'b0};
      vecs[4]  = '{1'b0, 3'd0, 16'h0000, 2'b10, 3'd3, 3'd3, 3'd3, 8'h00,  16'h0054, 4, 1'b0, 1'b0};
      vecs[5]  = '{1'b1, 3'd1, 16'h00F0, 2'b11, 3'd4, 3'd1, 3'd2, 8'h00,  16'h0000, 4, 1'b1, 1'b0};
      vecs[6]  = '{1'b1, 3'd7, 16'hFFFF, 2'b00, 3'd0, 3'd0, 3'd0, 8'h01,  16'h0001, 2, 1'b0, 1'b0};
      vecs[7]  = '{1'b0, 3'd0, 16'h0000, 2'b10, 3'd4, 3'd7, 3'd0, 8'h00,  16'h0000, 4, 1'b1, 1'b0};
      vecs[8]  = '{1'b0, 3'd0, 16'h0000, 2'b10, 3'd6, 3'd2, 3'd1, 8'h00,  16'h0FFF, 4, 1'b0, 1'b0};
      vecs[9]  = '{1'b0, 3'd0, 16'h0000, 2'b01, 3'd0, 3'd0, 3'd0, 8'h00,  16'h0001, 3, 1'b0, 1'b0};
      vecs[10] = '{1'b0, 3'd0, 16'h0000, 2'b00, 3'd7, 3'd0, 3'd0, 8'h80,  16'hFF80, 2, 1'b0, 1'b1};
      for (int i = 0; i < 11; i++) run_op(vecs[i]);

      // start held high through an ADD; inputs change while busy.
      @(negedge clk);
      drive(2'b10, 3'd7, 3'd1, 3'd2, 8'h00);
      mdl[7] = 16'h0FFF;
      @(negedge clk);
      drive(2'b00, 3'd0, 3'd0, 3'd0, 8'h05);
      dn = 0; dncyc = 0; wr = 0;
      for (int c = 1; c <= 4; c++) begin
         chk("held_busy", 32'(busy), 32'd1);
         if (done) begin dn++; dncyc = c; end
         if (rf.write) wr++;
         @(negedge clk);
      end
      chk("held_done_count", 32'(dn), 32'd1);
      chk("held_done_cycle", 32'(dncyc), 32'd4);
      chk("held_write_count", 32'(wr), 32'd1);
      chk("held_R7", 32'(regs[7]), 32'h0FFF);
      chk("held_idle_busy", 32'(busy), 32'd0);
      chk("held_R0_old", 32'(regs[0]), 32'h0001);
      @(negedge clk);
      start = 1'b0;
      chk("second_write", 32'(rf.write), 32'd1);
      chk("second_writenum", 32'(rf.writenum), 32'd0);
      chk("second_data_in", 32'(rf.data_in), 32'h0005);
      @(negedge clk);
      chk("second_done", 32'(done), 32'd1);
      mdl[0] = 16'h0005;
      chk_all();
      @(negedge clk);

      // Reset during LOADB of MOV R2,R1, after an op leaving Z=1.
      v = '{1'b0, 3'd0, 16'h0000, 2'b00, 3'd4, 3'd0, 3'd0, 8'h00, 16'h0000, 2, 1'b1, 1'b0};
      run_op(v);
      @(negedge clk);
      drive(2'b01, 3'd2, 3'd0, 3'd1, 8'h00);
      @(negedge clk);
      start = 1'b0;
      chk("loadb_readnum", 32'(rf.readnum), 32'd1);
      reset = 1'b1;
      #1 chk("loadb_rst_write", 32'(rf.write), 32'd0);
      @(negedge clk);
      reset = 1'b0;
      chk_reset_outs("rst_loadb");
      @(negedge clk);
      chk("loadb_rst_idle_write", 32'(rf.write), 32'd0);
      chk_all();

      // Reset during WRITE of ADD R5,R1,R1, after an op leaving N=1.
      v = '{1'b0, 3'd0, 16'h0000, 2'b00, 3'd4, 3'd0, 3'd0, 8'h9C, 16'hFF9C, 2, 1'b0, 1'b1};
      run_op(v);
      @(negedge clk);
      drive(2'b10, 3'd5, 3'd1, 3'd1, 8'h00);
      @(negedge clk);
      start = 1'b0;
      @(negedge clk);
      @(negedge clk);
      chk("write_cycle_pre", 32'(rf.write), 32'd1);
      reset = 1'b1;
      #1 chk("write_rst_gated", 32'(rf.write), 32'd0);
      @(negedge clk);
      reset = 1'b0;
      chk_reset_outs("rst_write");
      chk("rst_write_R5", 32'(regs[5]), 32'h0054);
      chk_all();

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
